// File: rtl/count_display_pkg.sv
// Shared types and constants for the count display driver.
// Scan state encoding, blanking values and the active-low digit segment table.
package count_display_pkg;

  typedef enum logic {
    SCAN_ONES = 1'b0,
    SCAN_TENS = 1'b1
  } scan_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [1:0] AN_OFF    = 2'b11;

  // {g,f,e,d,c,b,a}, active-low, digits 0..9
  localparam logic [6:0] SEG_TABLE [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

endpackage

// File: rtl/count_display_driver_decoder.sv
// Combinational BCD to active-low 7-segment decoder.
// Codes above 9 cannot occur in this design and decode to a blank digit.
module seven_seg_decoder
  import count_display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (bcd < 4'd10) begin
      seg = SEG_TABLE[bcd];
    end
  end

endmodule

// File: rtl/count_display_driver.sv
// Samples an asynchronous ripple-counter value, filters ripple glitches and drives
// a 2-digit multiplexed 7-segment display. Optional macro: DIR_INDICATOR_EN.
module count_display_driver
  import count_display_pkg::*;
#(
  parameter int REFRESH_DIV   = 50000,
  parameter int STABLE_CYCLES = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] COUNT,
  input  logic       UPDN,
  output logic [6:0] SEG,
  output logic [1:0] AN,
  output logic       DP,
  output logic       CHANGED
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int SW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [SW-1:0] STAB_LAST  = SW'(STABLE_CYCLES - 1);

  logic [3:0] cnt_s;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_cnt_sync
      logic meta_reg;
      logic sync_reg;
      always_ff @(posedge CLK) begin
        if (RESET) begin
          meta_reg <= 1'b0;
          sync_reg <= 1'b0;
        end else begin
          meta_reg <= COUNT[gi];
          sync_reg <= meta_reg;
        end
      end
      assign cnt_s[gi] = sync_reg;
    end
  endgenerate

  logic [3:0]    cnt_prev_reg;
  logic [SW-1:0] stab_cnt_reg, stab_cnt_next;
  logic [3:0]    value_reg;
  logic          tens_reg;
  logic [3:0]    ones_reg;
  logic          load;

  // stab_cnt_next is the run length of identical samples minus one, including this one
  always_comb begin
    stab_cnt_next = '0;
    if (cnt_s == cnt_prev_reg) begin
      stab_cnt_next = (stab_cnt_reg == STAB_LAST) ? stab_cnt_reg : stab_cnt_reg + 1'b1;
    end
    load = (stab_cnt_next == STAB_LAST) && (cnt_s != value_reg);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_prev_reg <= '0;
      stab_cnt_reg <= '0;
      value_reg    <= '0;
      tens_reg     <= 1'b0;
      ones_reg     <= '0;
    end else begin
      cnt_prev_reg <= cnt_s;
      stab_cnt_reg <= stab_cnt_next;
      if (load) begin
        value_reg <= cnt_s;
        if (cnt_s >= 4'd10) begin
          tens_reg <= 1'b1;
          ones_reg <= cnt_s - 4'd10;
        end else begin
          tens_reg <= 1'b0;
          ones_reg <= cnt_s;
        end
      end
    end
  end

  scan_t         scan_reg, scan_next;
  logic [PW-1:0] presc_reg, presc_next;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      scan_reg  <= SCAN_ONES;
      presc_reg <= '0;
    end else begin
      scan_reg  <= scan_next;
      presc_reg <= presc_next;
    end
  end

  always_comb begin
    scan_next  = scan_reg;
    presc_next = presc_reg + 1'b1;
    if (presc_reg == PRESC_LAST) begin
      presc_next = '0;
      scan_next  = (scan_reg == SCAN_ONES) ? SCAN_TENS : SCAN_ONES;
    end
  end

  logic [3:0] dec_in;
  logic [6:0] dec_seg;

  assign dec_in = (scan_reg == SCAN_TENS) ? {3'b000, tens_reg} : ones_reg;

  seven_seg_decoder u_decoder (
    .bcd (dec_in),
    .seg (dec_seg)
  );

`ifdef DIR_INDICATOR_EN
  logic dir_m_reg, dir_s_reg;
  always_ff @(posedge CLK) begin
    if (RESET) begin
      dir_m_reg <= 1'b0;
      dir_s_reg <= 1'b0;
    end else begin
      dir_m_reg <= UPDN;
      dir_s_reg <= dir_m_reg;
    end
  end
`else
  logic unused_updn;
  assign unused_updn = UPDN;
`endif

  logic [1:0] an_reg, an_next;
  logic [6:0] seg_reg, seg_next;
  logic       dp_reg, dp_next;
  logic       changed_reg;

  always_comb begin
    an_next  = 2'b10;
    seg_next = dec_seg;
    dp_next  = 1'b1;
    if (scan_reg == SCAN_TENS) begin
      an_next = 2'b01;
      if (!tens_reg) begin
        seg_next = SEG_BLANK;
      end
    end
`ifdef DIR_INDICATOR_EN
    else begin
      dp_next = ~dir_s_reg;
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      an_reg      <= AN_OFF;
      seg_reg     <= SEG_BLANK;
      dp_reg      <= 1'b1;
      changed_reg <= 1'b0;
    end else begin
      an_reg      <= an_next;
      seg_reg     <= seg_next;
      dp_reg      <= dp_next;
      changed_reg <= load;
    end
  end

  assign SEG     = seg_reg;
  assign AN      = an_reg;
  assign DP      = dp_reg;
  assign CHANGED = changed_reg;

endmodule

// File: tb/tb_count_display_driver.sv
// Scoreboard bench for count_display_driver with REFRESH_DIV=4, STABLE_CYCLES=3.
// Expected values are queued when COUNT is driven and checked on each CHANGED pulse.
module tb_count_display_driver;

  logic       clk = 1'b0;
  logic       RESET = 1'b1;
  logic [3:0] COUNT = 4'd0;
  logic       UPDN = 1'b0;
  logic [6:0] SEG;
  logic [1:0] AN;
  logic       DP;
  logic       CHANGED;

  always #5 clk = ~clk;

  count_display_driver #(.REFRESH_DIV(4), .STABLE_CYCLES(3)) dut (
    .CLK     (clk),
    .RESET   (RESET),
    .COUNT   (COUNT),
    .UPDN    (UPDN),
    .SEG     (SEG),
    .AN      (AN),
    .DP      (DP),
    .CHANGED (CHANGED)
  );

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int exp_q[$];
  int exp_cur = 0;
  bit chk_pending = 1'b0;

  logic [6:0] seg_tab [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  function automatic logic [6:0] exp_seg(input int v, input logic [1:0] an);
    if (an == 2'b10) return seg_tab[v % 10];
    return (v >= 10) ? seg_tab[1] : 7'h7F;
  endfunction

  // Scoreboard: each CHANGED pulse consumes one queued value; the next cycle must show it
  always @(negedge clk) begin
    if (chk_pending) begin
      checks++;
      if (!(AN == 2'b10 || AN == 2'b01) || SEG !== exp_seg(exp_cur, AN)) begin
        errors++;
        $display("FAIL changed_display: AN=%b SEG=%b, required value %0d SEG=%b",
                 AN, SEG, exp_cur, exp_seg(exp_cur, AN));
      end else begin
        $display("changed -> value %0d shown AN=%b SEG=%b", exp_cur, AN, SEG);
      end
      chk_pending = 1'b0;
    end
    if (CHANGED === 1'b1) begin
      pulses++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL changed_unexpected: CHANGED=1, required 0 (no value pending)");
      end else begin
        exp_cur = exp_q.pop_front();
        chk_pending = 1'b1;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    logic [1:0] exp_an;
    logic [6:0] exp_sg;
    RESET = 1'b1;
    COUNT = 4'd0;
    UPDN  = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (AN !== 2'b11 || SEG !== 7'h7F || DP !== 1'b1 || CHANGED !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: AN=%b SEG=%b DP=%b CHANGED=%b, required 11 1111111 1 0",
               AN, SEG, DP, CHANGED);
    end else $display("reset: AN=%b SEG=%b DP=%b CHANGED=%b", AN, SEG, DP, CHANGED);
    RESET = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      exp_an = (((i / 4) % 2) == 0) ? 2'b10 : 2'b01;
      exp_sg = (exp_an == 2'b10) ? seg_tab[0] : 7'h7F;
      checks++;
      if (AN !== exp_an || SEG !== exp_sg) begin
        errors++;
        $display("FAIL scan_cycle%0d: AN=%b SEG=%b, required AN=%b SEG=%b", i, AN, SEG, exp_an, exp_sg);
      end else $display("scan cycle %0d: AN=%b SEG=%b", i, AN, SEG);
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL reset_no_pulse: pulses=%0d, required 0", pulses);
    end
  endtask

  task automatic test_change_12();
    int p0, lat, run;
    bit found, run_valid, bad_seg, bad_run;
    logic [1:0] prev_an;
    p0 = pulses; lat = 0; found = 0;
    COUNT = 4'd12;
    exp_q.push_back(12);
    for (int i = 1; i <= 10 && !found; i++) begin
      @(negedge clk);
      if (CHANGED === 1'b1) begin
        found = 1; lat = i;
      end
    end
    checks++;
    if (!found || lat < 5 || lat > 6) begin
      errors++;
      $display("FAIL change_latency: found=%0d latency=%0d, required 5..6", found, lat);
    end else $display("change 0->12: CHANGED after %0d edges", lat);
    bad_seg = 0; bad_run = 0; run_valid = 0; run = 0;
    @(negedge clk);
    prev_an = AN;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!(AN == 2'b10 || AN == 2'b01) || SEG !== exp_seg(12, AN)) bad_seg = 1;
      if (AN == prev_an) run++;
      else begin
        if (run_valid && run != 4) bad_run = 1;
        run_valid = 1; run = 1; prev_an = AN;
      end
    end
    checks++;
    if (bad_seg) begin
      errors++;
      $display("FAIL display_12: last AN=%b SEG=%b, required SEG=%b", AN, SEG, exp_seg(12, AN));
    end else $display("display 12: digits 1 and 2 alternate");
    checks++;
    if (bad_run || !run_valid) begin
      errors++;
      $display("FAIL scan_period: phase run=%0d, required 4", run);
    end
    checks++;
    if (pulses - p0 != 1) begin
      errors++;
      $display("FAIL change_12_pulses: %0d, required 1", pulses - p0);
    end
  endtask

  task automatic test_ripple();
    int p0;
    bit bad;
    COUNT = 4'd7;
    exp_q.push_back(7);
    repeat (12) @(negedge clk);
    p0 = pulses; bad = 0;
    COUNT = 4'd6;
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      if (i == 0) COUNT = 4'd4;
      if (i == 1) begin
        COUNT = 4'd8;
        exp_q.push_back(8);
      end
      if (SEG === seg_tab[6] || SEG === seg_tab[4]) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL ripple_glitch: transient 6 or 4 reached SEG, required never");
    end else $display("ripple 7->6->4->8: no transient shown");
    checks++;
    if (SEG !== exp_seg(8, AN)) begin
      errors++;
      $display("FAIL ripple_final: AN=%b SEG=%b, required SEG=%b", AN, SEG, exp_seg(8, AN));
    end
    checks++;
    if (pulses - p0 != 1) begin
      errors++;
      $display("FAIL ripple_pulses: %0d, required 1", pulses - p0);
    end
  endtask

  task automatic test_wrap();
    int p0;
    bit bad15, bad0;
    COUNT = 4'd15;
    exp_q.push_back(15);
    repeat (10) @(negedge clk);
    bad15 = 0; bad0 = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (!(AN == 2'b10 || AN == 2'b01) || SEG !== exp_seg(15, AN)) bad15 = 1;
    end
    checks++;
    if (bad15) begin
      errors++;
      $display("FAIL display_15: AN=%b SEG=%b, required SEG=%b", AN, SEG, exp_seg(15, AN));
    end else $display("display 15 shown");
    p0 = pulses;
    COUNT = 4'd0;
    exp_q.push_back(0);
    repeat (10) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (!(AN == 2'b10 || AN == 2'b01) || SEG !== exp_seg(0, AN)) bad0 = 1;
    end
    checks++;
    if (bad0) begin
      errors++;
      $display("FAIL display_wrap0: AN=%b SEG=%b, required SEG=%b", AN, SEG, exp_seg(0, AN));
    end else $display("wrap 15->0: tens blanked, ones 0");
    checks++;
    if (pulses - p0 != 1) begin
      errors++;
      $display("FAIL wrap_pulses: %0d, required 1", pulses - p0);
    end
  endtask

  task automatic test_reset_mid();
    int p0;
    bit found;
    COUNT = 4'd9;
    exp_q.push_back(9);
    repeat (10) @(negedge clk);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (AN === 2'b01) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL tens_phase_wait: AN=%b, required 01 within 10 cycles", AN);
    end
    p0 = pulses;
    RESET = 1'b1;
    @(negedge clk);
    checks++;
    if (AN !== 2'b11 || SEG !== 7'h7F || CHANGED !== 1'b0 || DP !== 1'b1) begin
      errors++;
      $display("FAIL midreset_state: AN=%b SEG=%b CHANGED=%b DP=%b, required 11 1111111 0 1",
               AN, SEG, CHANGED, DP);
    end else $display("mid reset: AN=%b SEG=%b", AN, SEG);
    RESET = 1'b0;
    exp_q.push_back(9);
    @(negedge clk);
    checks++;
    if (AN !== 2'b10 || SEG !== seg_tab[0] || pulses != p0) begin
      errors++;
      $display("FAIL midreset_release: AN=%b SEG=%b pulses=%0d, required 10 1000000 %0d",
               AN, SEG, pulses, p0);
    end else $display("after release: AN=%b SEG=%b", AN, SEG);
    repeat (12) @(negedge clk);
  endtask

  task automatic test_dp();
    bit bad_up, bad_dn;
    bad_up = 0; bad_dn = 0;
    UPDN = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
`ifdef DIR_INDICATOR_EN
      if (DP !== ((AN == 2'b10) ? 1'b0 : 1'b1)) bad_up = 1;
`else
      if (DP !== 1'b1) bad_up = 1;
`endif
    end
    checks++;
    if (bad_up) begin
      errors++;
      $display("FAIL dp_up: DP=%b AN=%b", DP, AN);
    end else $display("UPDN=1: DP=%b AN=%b", DP, AN);
    UPDN = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (DP !== 1'b1) bad_dn = 1;
    end
    checks++;
    if (bad_dn) begin
      errors++;
      $display("FAIL dp_down: DP=%b, required 1", DP);
    end else $display("UPDN=0: DP=%b", DP);
  endtask

  initial begin
    test_reset();
    test_change_12();
    test_ripple();
    test_wrap();
    test_reset_mid();
    test_dp();
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || chk_pending) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d values pending, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/count_display_driver.md
Name: count_display_driver

Overview:
Downstream consumer of the 4-bit asynchronous up/down counter. Samples the ripple counter's COUNT bus into the CLK domain and filters ripple glitches with a stability check. Converts the accepted value (0-15) to two BCD digits and drives a 2-digit, time-multiplexed, active-low 7-segment display. Also emits a one-cycle pulse whenever the displayed value changes.

Parameters:
REFRESH_DIV, 50000, CLK cycles each digit is lit before the scan advances (>=2)
STABLE_CYCLES, 4, consecutive identical synchronized samples required before a COUNT value is accepted (>=1)

Ports:
CLK  input  1  system clock; all state on rising edge
RESET  input  1  synchronous, active-high reset
COUNT  input  4  counter value from the ripple counter; asynchronous to CLK
UPDN  input  1  counter direction (1 = up); asynchronous to CLK
SEG  output  7  segments {g,f,e,d,c,b,a}, active-low, registered
AN  output  2  digit enables, active-low; AN[0] = ones, AN[1] = tens; registered
DP  output  1  decimal point, active-low, registered
CHANGED  output  1  one-cycle pulse when the accepted value changes

Behaviour:
- Single clock, CLK. RESET is synchronous and active-high and overrides all other logic.
- Reset values:
  - Sync flops, accepted VALUE, stability counter, prescaler: all 0.
  - Scan state: SCAN_ONES.
  - Outputs: AN=2'b11, SEG=7'h7F, DP=1, CHANGED=0.
- Synchronizer: COUNT and UPDN each pass through 2 flops, giving cnt_s and dir_s.
- Stability filter:
  - stab_cnt clears to 0 when cnt_s differs from its previous sample. Otherwise it increments, saturating at STABLE_CYCLES-1.
  - VALUE loads cnt_s on the edge where cnt_s has been identical for STABLE_CYCLES consecutive samples and differs from VALUE.
  - Latency from a settled COUNT change to VALUE update: 2+STABLE_CYCLES edges.
  - Transient ripple values held for fewer than STABLE_CYCLES samples are never accepted.
- CHANGED: high for exactly the cycle after VALUE loads a new, different value. It never fires for an unchanged value and never fires on reset.
- BCD conversion, registered alongside VALUE:
  - VALUE>=10: TENS=1, ONES=VALUE-10.
  - Otherwise: TENS=0, ONES=VALUE.
- Prescaler: counts 0..REFRESH_DIV-1 and wraps. Terminal count toggles the scan state SCAN_ONES <-> SCAN_TENS.
- Output register, updated every cycle from the current scan state:
  - SCAN_ONES: AN=2'b10, SEG=decode(ONES).
  - SCAN_TENS: AN=2'b01, SEG=decode(TENS). If TENS=0 (leading-zero blanking), SEG=7'h7F.
  - Outputs lag the state by one cycle.
  - First cycle after reset release: AN=2'b10, SEG=decode(0)=7'b1000000.
- Segment codes: 0=1000000, 1=1111001, 2=0100100, 5=0010010, 8=0000000, 9=0010000. The decoder covers 0-9; codes 10-15 are unreachable and decode to 7'h7F.
- Wrap-around: 15->0 and 0->15 are ordinary changes. Display shows "15" -> " 0" (tens blanked) and back.
- Reset mid-operation: the next edge blanks the display and clears VALUE. No CHANGED pulse occurs on reset or on the subsequent first acceptance of 0.

Optional Feature:
Macro DIR_INDICATOR_EN.
- Defined: DP = ~dir_s during SCAN_ONES, i.e. the dot is lit while counting up. DP = 1 during SCAN_TENS.
- Undefined: DP is held at 1, and UPDN is left unconnected internally (no sync flops).

Decomposition:
- Package count_display_pkg:
  - scan state typedef (SCAN_ONES, SCAN_TENS)
  - SEG_BLANK = 7'h7F
  - AN_OFF = 2'b11
  - 10-entry segment code table
- Sub-module seven_seg_decoder: purely combinational, 4-bit BCD in, 7-bit active-low segments out. Instantiated once, with its input muxed by scan state.

Test Plan:
All runs use REFRESH_DIV=4, STABLE_CYCLES=3.
1. Hold RESET 3 cycles -> AN=11, SEG=7F, DP=1, CHANGED=0. Release -> AN=10, SEG=1000000. Scan toggles every 4 cycles; the tens phase is blanked (SEG=7F).
2. COUNT 0->12, held -> exactly one CHANGED pulse 5-6 edges later. Ones phase SEG=0100100, tens phase SEG=1111001, alternating every 4 cycles.
3. Ripple 7->6->4->8 with 6 and 4 each held 1 CLK cycle -> VALUE goes 7->8 directly, one CHANGED pulse, and no 6 or 4 ever on SEG.
4. COUNT 15->0 (up wrap) -> display goes "15" -> " 0": tens blanked, ones SEG=1000000, one CHANGED pulse.
5. VALUE=9 during the tens phase, assert RESET for 1 cycle -> next edge AN=11, SEG=7F, CHANGED=0. After release the ones digit shows 0.
6. With DIR_INDICATOR_EN: UPDN=1 -> DP=0 in the ones phase only. UPDN=0 -> DP=1 throughout, within 3 edges. Without the macro: DP=1 always.
